loom_feedback_sink: RTL

//  Receiving end of the Loom feedback path. Captures loom_packet_t deltas (valid-only, no backpressure).

---
 rtl/loom_feedback_sink.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/loom_feedback_sink.sv
// Loom feedback sink: buffers whole feedback deltas in a small FIFO and
// streams each one to the Reservoir port as BEATS slices over valid/ready.
// Deltas that arrive while the FIFO is full are dropped and counted.

package helix_pkg;
    localparam int FEEDBACK_W = 384;

    typedef struct packed {
        logic [FEEDBACK_W-1:0] delta;
        logic                  valid;
    } loom_packet_t;
endpackage

module loom_feedback_sink
    import helix_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int SLICE_W = 128,
    parameter  int CNT_W   = 16,
    localparam int BEATS   = FEEDBACK_W / SLICE_W,
    localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  loom_packet_t       in_pkt,
    output logic [SLICE_W-1:0] out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               overflow,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    if (FEEDBACK_W % SLICE_W != 0) begin : g_bad_slice
        $error("loom_feedback_sink: FEEDBACK_W must be a multiple of SLICE_W");
    end

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("loom_feedback_sink: DEPTH must be a power of two and at least 2");
    end

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                state;
    logic [FEEDBACK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  handshake;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  full;
    logic [LVL_W-1:0]      level_next;

    // Push/pop/drop decisions; a pop frees room for a push in the same cycle
    always_comb begin
        handshake  = out_valid && out_ready;
        pop        = handshake && out_last;
        full       = (fifo_level == LVL_W'(DEPTH));
        push       = in_pkt.valid && (!full || pop);
        drop       = in_pkt.valid && full && !pop;
        level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);
    end

    // Head slice selected by the registered beat index, so it holds during a stall
    assign out_data = mem[rd_ptr][int'(out_idx) * SLICE_W +: SLICE_W];

    // Delta storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_pkt.delta;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= level_next;
        end
    end

    // Serializer: walks the head delta slice by slice, chaining into the next delta without a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (level_next != '0) begin
                        state     <= S_SEND;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_last  <= (BEATS == 1);
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        if (out_last) begin
                            out_idx  <= '0;
                            out_last <= (BEATS == 1);
                            if (level_next == '0) begin
                                state     <= S_IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_last <= ((int'(out_idx) + 1) == (BEATS - 1));
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    out_idx   <= '0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // Overflow pulse and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            overflow <= drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
